// File: rtl/keypad_pkg.sv
// Shared types and key-map definitions for the 4x4 matrix keypad scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    SCAN     = 2'd0,
    DEBOUNCE = 2'd1,
    PRESSED  = 2'd2
  } state_t;

  localparam logic [3:0] KEY_STAR = 4'hE;
  localparam logic [3:0] KEY_HASH = 4'hF;

  // Physical keypad legend, indexed by {row, col}.
  function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
    logic [3:0] code;
    code = 4'h0;
    case ({row, col})
      4'h0: code = 4'h1;
      4'h1: code = 4'h2;
      4'h2: code = 4'h3;
      4'h3: code = 4'hA;
      4'h4: code = 4'h4;
      4'h5: code = 4'h5;
      4'h6: code = 4'h6;
      4'h7: code = 4'hB;
      4'h8: code = 4'h7;
      4'h9: code = 4'h8;
      4'hA: code = 4'h9;
      4'hB: code = 4'hC;
      4'hC: code = KEY_STAR;
      4'hD: code = 4'h0;
      4'hE: code = KEY_HASH;
      4'hF: code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/keypad_scanner_key_to_char.sv
// Combinational translation of a keypad code into the ASCII character shown on the display.
module key_to_char
  import keypad_pkg::*;
(
  input  logic [3:0] i_code,
  output logic [7:0] o_char
);

  always_comb begin
    o_char = 8'h20;
    if (i_code <= 4'h9) begin
      o_char = 8'h30 + {4'h0, i_code};
    end else if (i_code == KEY_STAR) begin
      o_char = 8'h2A;
    end else if (i_code == KEY_HASH) begin
      o_char = 8'h23;
    end else begin
      o_char = 8'h41 + {4'h0, i_code - 4'hA};
    end
  end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column multiplexing, row synchronisation,
// press/release debouncing and one key event per accepted press.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 8
)
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic [7:0] key_char,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DW_W  = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DW_W-1:0]  DWELL_LAST = DW_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] DB_LAST    = CNT_W'(DEBOUNCE_SCANS - 1);

  logic [3:0]       r_row_s1;
  logic [3:0]       r_row_s2;
  logic [DW_W-1:0]  r_dwell;
  logic [1:0]       r_col;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_cap_row;
  logic [3:0]       r_key_code;
  logic [7:0]       r_key_char;
  logic             r_key_valid;
  logic             r_key_held;

  logic             w_dwell_end;
  logic             w_any_low;
  logic             w_cap_low;
  logic [1:0]       w_low_row;
  logic [3:0]       w_map_code;
  logic [7:0]       w_map_char;
  state_t           w_state_nxt;
  logic [1:0]       w_col_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_cap_row_nxt;
  logic [3:0]       w_code_nxt;
  logic [7:0]       w_char_nxt;
  logic             w_valid_nxt;
  logic             w_held_nxt;

  assign w_dwell_end = (r_dwell == DWELL_LAST);
  assign w_any_low   = ~&r_row_s2;
  assign w_cap_low   = ~r_row_s2[r_cap_row];
  assign w_map_code  = key_map(r_cap_row, r_col);

  // Lowest-numbered low row has priority when several keys share a column.
  always_comb begin
    w_low_row = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!r_row_s2[i]) w_low_row = 2'(i);
    end
  end

  key_to_char u_key_to_char (
    .i_code (w_map_code),
    .o_char (w_map_char)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_s1 <= 4'hF;
      r_row_s2 <= 4'hF;
      r_dwell  <= '0;
    end else begin
      r_row_s1 <= row_n;
      r_row_s2 <= r_row_s1;
      r_dwell  <= w_dwell_end ? '0 : r_dwell + DW_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SCAN;
      r_col       <= 2'd0;
      r_cnt       <= '0;
      r_cap_row   <= 2'd0;
      r_key_code  <= 4'h0;
      r_key_char  <= 8'h20;
      r_key_valid <= 1'b0;
      r_key_held  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_col       <= w_col_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cap_row   <= w_cap_row_nxt;
      r_key_code  <= w_code_nxt;
      r_key_char  <= w_char_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_held  <= w_held_nxt;
    end
  end

  // The column stays on the captured key while debouncing or held, so r_col doubles as the captured column.
  always_comb begin
    w_state_nxt   = r_state;
    w_col_nxt     = r_col;
    w_cnt_nxt     = r_cnt;
    w_cap_row_nxt = r_cap_row;
    w_code_nxt    = r_key_code;
    w_char_nxt    = r_key_char;
    w_valid_nxt   = 1'b0;
    w_held_nxt    = r_key_held;
    if (w_dwell_end) begin
      case (r_state)
        SCAN: begin
          if (w_any_low) begin
            w_cap_row_nxt = w_low_row;
            w_state_nxt   = DEBOUNCE;
            w_cnt_nxt     = CNT_W'(1);
          end else begin
            w_col_nxt = r_col + 2'd1;
          end
        end
        DEBOUNCE: begin
          if (w_cap_low) begin
            if (r_cnt == DB_LAST) begin
              w_state_nxt = PRESSED;
              w_cnt_nxt   = '0;
              w_code_nxt  = w_map_code;
              w_char_nxt  = w_map_char;
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_state_nxt = SCAN;
            w_cnt_nxt   = '0;
            w_col_nxt   = r_col + 2'd1;
          end
        end
        PRESSED: begin
          if (!w_cap_low) begin
            if (r_cnt == DB_LAST) begin
              w_state_nxt = SCAN;
              w_cnt_nxt   = '0;
              w_held_nxt  = 1'b0;
              w_col_nxt   = r_col + 2'd1;
            end else begin
              w_cnt_nxt = r_cnt + CNT_W'(1);
            end
          end else begin
            w_cnt_nxt = '0;
          end
        end
        default: begin
          w_state_nxt = SCAN;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  assign col_n     = ~(4'b0001 << r_col);
  assign key_code  = r_key_code;
  assign key_char  = r_key_char;
  assign key_valid = r_key_valid;
  assign key_held  = r_key_held;

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Scans a 4x4 matrix keypad. Drives one column low at a time (active-low, one-hot, time-division multiplexed) and reads the four active-low row lines.
- Debounces presses and releases, then reports one event per press as a 4-bit key code and an 8-bit ASCII character.
- Sits on the board input side and mirrors the multiplexed display driver on the output side. key_char connects directly to the display's 8-bit character inputs.

Parameters:
- SCAN_DIV, default 1000: clock cycles each column stays driven (dwell). Must be >= 4.
- DEBOUNCE_SCANS, default 8: consecutive matching dwell-end samples needed to accept a press or a release. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row_n  input  4  keypad rows, active-low, asynchronous to clk
- col_n  output  4  keypad column drive, active-low one-hot
- key_code  output  4  code of the last accepted key
- key_char  output  8  ASCII of the last accepted key
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high while the accepted key is held

Behaviour:
- Reset values (asynchronous, active-low): col index 0, col_n=4'b1110, dwell counter 0, debounce counter 0, state SCAN, key_code=0, key_char=8'h20, key_valid=0, key_held=0.
- Reset asserted mid-operation returns to this condition immediately. Any in-progress debounce is discarded, and no key_valid pulse is produced.
- Row synchronizer: row_n passes through a 2-flop synchronizer before any use.
- Dwell timing: the dwell counter runs 0..SCAN_DIV-1. Rows are sampled only at count SCAN_DIV-1 (the dwell end), giving at least 2 settle cycles.
- Column advance: only in state SCAN, at the dwell end, col index = col+1 mod 4. Wraps 3 to 0.
- State SCAN:
  - At dwell end, if any synchronized row is low, capture (row, col) and go to DEBOUNCE with cnt=1.
  - The column is then frozen on the captured col.
  - If several rows are low, the lowest row index wins. Across columns, scan order decides.
- State DEBOUNCE:
  - At each dwell end, if the captured row is still low, cnt++. Otherwise return to SCAN; the column advances from the captured col.
  - When cnt reaches DEBOUNCE_SCANS, go to PRESSED with cnt=0.
  - On that same transition edge, register the outputs: key_code, key_char, key_valid=1 (for exactly one cycle), key_held=1.
- State PRESSED:
  - Column stays frozen and no new key events are produced. Other keys are ignored.
  - At each dwell end, if the captured row is high, cnt++; if low, cnt=0.
  - When cnt reaches DEBOUNCE_SCANS, go to SCAN, clear key_held, and advance the column.
  - key_code and key_char hold their last value.
- Key map (row r, col c), codes in hex:
  - r0: 1,2,3,A
  - r1: 4,5,6,B
  - r2: 7,8,9,C
  - r3: E(*),0,F(#),D
- ASCII: digits map to 8'h30+code. A–D map to 8'h41–8'h44. E maps to 8'h2A ('*'). F maps to 8'h23 ('#').
- Accept latency: key_valid is asserted 1 cycle after the dwell end of the DEBOUNCE_SCANS-th consecutive low sample.
- Release latency: the DEBOUNCE_SCANS-th consecutive high sample is needed before key_held drops.

Decomposition:
- Package keypad_pkg contains:
  - the state enum (SCAN, DEBOUNCE, PRESSED)
  - key code constants KEY_STAR=4'hE and KEY_HASH=4'hF
  - the (row, col)-to-code map
- Sub-module key_to_char: combinational 4-bit code to 8-bit ASCII, instantiated once.
- The synchronizer and FSM stay in keypad_scanner.

Test Plan:
All scenarios use SCAN_DIV=4 and DEBOUNCE_SCANS=3.
- Idle, no keys pressed:
  - col_n cycles 1110 → 1101 → 1011 → 0111 → 1110, each value held 4 cycles.
  - key_valid and key_held never assert.
- Press key '5' (row1 low whenever col1 is driven) and hold:
  - key_valid pulses for exactly 1 cycle.
  - key_code=4'h5, key_char=8'h35, key_held=1, col_n frozen at 1101.
- Release key '5':
  - key_held goes to 0 after 3 consecutive high dwell-end samples.
  - Scanning resumes with col_n=1011. key_char stays 8'h35.
- Bounce on '#' (row3/col2): low for 2 dwell samples, then high:
  - No key_valid pulse.
  - State returns to SCAN and col_n advances to 0111.
- Simultaneous '4' (r1c0) and '1' (r0c0):
  - key_code=4'h1 and key_char=8'h31.
  - Exactly one key_valid pulse while both are held.
- Assert rst_n low during DEBOUNCE (after 2 samples):
  - Outputs go to their reset values immediately and col_n=1110.
  - No key_valid pulse occurs after reset is released, until a fresh full debounce completes.
